regfile: RTL

Architectural integer register file at the ID end of the writeback path. It holds 32 general registers with x0 hardwired to zero. Each cycle it accepts at most one writeback (RegWrite, rd_addr, rd_data) from the WB stage and serves two combinational operand reads to the ID stage. A write-through bypass lets an instruction in ID read a value that WB is writing in the same cycle. A third read-only debug port exposes raw register contents to the test bench and the debug shell.

---
 rtl/regfile.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
// Architectural integer register file that sits between the WB and ID stages.
// x1..x(NREGS-1) are physical registers. x0 has no storage and always reads
// zero. There is one clocked writeback port and two combinational operand read
// ports with same-cycle write-through bypass. A third combinational debug
// port returns the raw stored contents with no bypass.
//
// Ports
//   clk          : single clock; storage updates on the rising edge
//   rst_n        : asynchronous active-low reset; clears storage and forces
//                  every read output to zero while low
//   wb_RegWrite  : writeback enable from WB
//   wb_rd_addr   : writeback destination register
//   wb_rd_data   : writeback value
//   rs1_addr     : ID read port 1 address
//   rs1_data     : ID read port 1 data (combinational, bypassed)
//   rs2_addr     : ID read port 2 address
//   rs2_data     : ID read port 2 data (combinational, bypassed)
//   dbg_addr     : debug read address
//   dbg_data     : raw stored contents of dbg_addr (combinational, no bypass)
// ----------------------------------------------------------------------------
module regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_RegWrite,
   input  logic [AW-1:0]   wb_rd_addr,
   input  logic [XLEN-1:0] wb_rd_data,
   input  logic [AW-1:0]   rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs2_data,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   // Physical storage. Index 0 does not exist, so x0 cannot hold a value.
   logic [XLEN-1:0] r_regs [1:NREGS-1];

   // One-hot write enables. Decoding the enable per register avoids any
   // variable index into the array, which has no entry for x0.
   logic [NREGS-1:1] w_we;

   // Stored (un-bypassed) values selected by each read address.
   logic [XLEN-1:0]  w_rs1_stored;
   logic [XLEN-1:0]  w_rs2_stored;
   logic [XLEN-1:0]  w_dbg_stored;

   // Same-cycle bypass hits on the operand ports.
   logic             w_rs1_hit;
   logic             w_rs2_hit;

   // Write-enable decode. A writeback to x0 matches no entry and is discarded.
   always_comb begin
      w_we = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (wb_RegWrite && (wb_rd_addr == AW'(i))) begin
            w_we[i] = 1'b1;
         end else begin
            w_we[i] = 1'b0;
         end
      end
   end

   // Storage update. Reset clears all registers at once; otherwise only the
   // enabled register loads and every other register holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREGS; i++) begin
            r_regs[i] <= {XLEN{1'b0}};
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (w_we[i]) begin
               r_regs[i] <= wb_rd_data;
            end else begin
               r_regs[i] <= r_regs[i];
            end
         end
      end
   end

   // Stored-value read muxes. Address 0 matches no entry and yields zero.
   always_comb begin
      w_rs1_stored = {XLEN{1'b0}};
      w_rs2_stored = {XLEN{1'b0}};
      w_dbg_stored = {XLEN{1'b0}};
      for (int i = 1; i < NREGS; i++) begin
         if (rs1_addr == AW'(i)) begin
            w_rs1_stored = r_regs[i];
         end else begin
            w_rs1_stored = w_rs1_stored;
         end
         if (rs2_addr == AW'(i)) begin
            w_rs2_stored = r_regs[i];
         end else begin
            w_rs2_stored = w_rs2_stored;
         end
         if (dbg_addr == AW'(i)) begin
            w_dbg_stored = r_regs[i];
         end else begin
            w_dbg_stored = w_dbg_stored;
         end
      end
   end

   // Bypass detection. A pending write to x0 never bypasses, because the
   // address-0 check below takes priority over the hit.
   always_comb begin
      w_rs1_hit = wb_RegWrite && (wb_rd_addr == rs1_addr);
      w_rs2_hit = wb_RegWrite && (wb_rd_addr == rs2_addr);
   end

   // Operand read port 1. Priority: reset, x0, bypass, stored value.
   always_comb begin
      rs1_data = {XLEN{1'b0}};
      if (!rst_n) begin
         rs1_data = {XLEN{1'b0}};
      end else if (rs1_addr == {AW{1'b0}}) begin
         rs1_data = {XLEN{1'b0}};
      end else if (w_rs1_hit) begin
         rs1_data = wb_rd_data;
      end else begin
         rs1_data = w_rs1_stored;
      end
   end

   // Operand read port 2. Identical to port 1 and independent of it.
   always_comb begin
      rs2_data = {XLEN{1'b0}};
      if (!rst_n) begin
         rs2_data = {XLEN{1'b0}};
      end else if (rs2_addr == {AW{1'b0}}) begin
         rs2_data = {XLEN{1'b0}};
      end else if (w_rs2_hit) begin
         rs2_data = wb_rd_data;
      end else begin
         rs2_data = w_rs2_stored;
      end
   end

   // Debug port. It shows only committed state, so a write becomes visible
   // here one edge later than on the operand ports.
   always_comb begin
      dbg_data = {XLEN{1'b0}};
      if (!rst_n) begin
         dbg_data = {XLEN{1'b0}};
      end else if (dbg_addr == {AW{1'b0}}) begin
         dbg_data = {XLEN{1'b0}};
      end else begin
         dbg_data = w_dbg_stored;
      end
   end

endmodule
